fifo_write_gen: RTL and testbench



---
 rtl/fifo_wr_gen_pkg.sv | 24 ++
 rtl/fifo_write_gen_if.sv | 28 ++
 rtl/fifo_write_gen_pattern_gen.sv | 68 ++++++
 rtl/fifo_write_gen.sv | 162 ++++++++++++++++
 tb/tb_fifo_write_gen.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_gen_pkg.sv
// Shared constants for the FIFO write-side traffic generator.
package fifo_wr_gen_pkg;

  // Controller states
  typedef logic [1:0] wr_state_t;
  localparam wr_state_t ST_IDLE   = 2'd0;
  localparam wr_state_t ST_SETTLE = 2'd1;
  localparam wr_state_t ST_WRITE  = 2'd2;

  // Data pattern select; 2'd3 falls back to increment
  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  // Maximal-length Galois (right-shift) tap masks for the supported widths
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/fifo_write_gen_if.sv
// FIFO write-port bundle: status flags in, write strobe and data out of the generator.
interface fifo_write_gen_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              almost_empty;
  logic              almost_full;
  logic              full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wdata;

  modport master (
    input  almost_empty,
    input  almost_full,
    input  full,
    output fifo_wr_en,
    output fifo_wdata
  );

  modport slave (
    output almost_empty,
    output almost_full,
    output full,
    input  fifo_wr_en,
    input  fifo_wdata
  );

endinterface

// File: rtl/fifo_write_gen_pattern_gen.sv
// Write-data register with increment / Galois LFSR / constant patterns.
// The pattern mode is captured on load so mid-burst mode changes are ignored.
module fifo_pattern_gen
  import fifo_wr_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic [DATA_W-1:0] data_o
);

  localparam logic [DATA_W-1:0] Taps = DATA_W'(lfsr_taps(DATA_W));

  logic [DATA_W-1:0] data_q, data_d, next_val, load_val;
  logic [1:0]        mode_q, mode_d;

  // Next pattern value from the current word and the latched mode
  always_comb begin
    next_val = data_q;
    case (mode_q)
      MODE_LFSR:  next_val = (data_q >> 1) ^ (data_q[0] ? Taps : '0);
      MODE_CONST: next_val = data_q;
      default:    next_val = data_q + DATA_W'(1);
    endcase
  end

  // Zero is the LFSR lock-up state, so a zero seed starts from 1 instead
  always_comb begin
    load_val = seed_i;
    if ((mode_i == MODE_LFSR) && (seed_i == '0)) begin
      load_val = DATA_W'(1);
    end
  end

  // Clear beats load beats advance
  always_comb begin
    data_d = data_q;
    mode_d = mode_q;
    if (clear_i) begin
      data_d = '0;
    end else if (load_i) begin
      data_d = load_val;
      mode_d = mode_i;
    end else if (advance_i) begin
      data_d = next_val;
    end
  end

  // Data and mode registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      mode_q <= MODE_INC;
    end else begin
      data_q <= data_d;
      mode_q <= mode_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/fifo_write_gen.sv
// FIFO write-side traffic generator: on a rising almost_empty edge, settle for
// SETTLE_CYC cycles, then write a generated burst until almost_full, full,
// disable or the burst limit. Reports per-burst word count and a burst counter.
module fifo_write_gen
  import fifo_wr_gen_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SETTLE_CYC = 10,
  parameter int unsigned BURST_MAX  = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  fifo_write_gen_if.master  fifo_if,
  output logic              busy_o,
  output logic              burst_done_o,
  output logic [CNT_W-1:0]  burst_words_o,
  output logic [CNT_W-1:0]  burst_count_o
);

  localparam logic [7:0]       SettleLast = 8'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] BurstLimit = CNT_W'(BURST_MAX);

  // Trigger path
  logic       s0_q, s1_q, s2_q;
  logic [1:0] sync_vld_q;
  logic       armed_q, armed_d;
  logic       trig;

  // Controller state
  wr_state_t        state_q, state_d;
  logic [7:0]       settle_q, settle_d;
  logic [CNT_W-1:0] word_q, word_d, word_inc;
  logic             wr_en_q, wr_en_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accepted, stop;
  logic             pg_load, pg_clear, pg_adv;

  // Synchronise almost_empty and keep an edge register running in every state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      s0_q       <= fifo_if.almost_empty;
      s1_q       <= s0_q;
      s2_q       <= s1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      armed_q    <= armed_d;
    end
  end

  // Edges are only honoured once a genuine low has been synchronised since
  // reset, so a level already high at reset release cannot fire a trigger.
  assign armed_d = armed_q | (sync_vld_q[1] & ~s1_q);
  assign trig    = s1_q & ~s2_q & armed_q;

  assign accepted = wr_en_q & ~fifo_if.full;
  assign word_inc = (accepted && (word_q != {CNT_W{1'b1}})) ? word_q + CNT_W'(1) : word_q;
  assign stop     = fifo_if.almost_full | fifo_if.full | ~enable_i |
                    ((BURST_MAX != 0) && (word_inc == BurstLimit));

  // Next-state and burst bookkeeping
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    word_d   = word_q;
    wr_en_d  = wr_en_q;
    done_d   = 1'b0;
    words_d  = words_q;
    count_d  = count_q;
    pg_load  = 1'b0;
    pg_clear = 1'b0;
    pg_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig && enable_i) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (settle_q == SettleLast) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
          pg_load = 1'b1;
          word_d  = '0;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_WRITE: begin
        word_d = word_inc;
        if (stop) begin
          state_d  = ST_IDLE;
          wr_en_d  = 1'b0;
          pg_clear = 1'b1;
          done_d   = 1'b1;
          words_d  = word_inc;
          count_d  = count_q + CNT_W'(1);
        end else begin
          pg_adv = accepted;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wr_en_d = 1'b0;
      end
    endcase
  end

  // Controller registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      word_q   <= '0;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
      words_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      word_q   <= word_d;
      wr_en_q  <= wr_en_d;
      done_q   <= done_d;
      words_q  <= words_d;
      count_q  <= count_d;
    end
  end

  fifo_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .load_i    (pg_load),
    .clear_i   (pg_clear),
    .advance_i (pg_adv),
    .mode_i    (mode_i),
    .seed_i    (seed_i),
    .data_o    (fifo_if.fifo_wdata)
  );

  assign fifo_if.fifo_wr_en = wr_en_q;
  assign busy_o             = (state_q == ST_SETTLE) || (state_q == ST_WRITE);
  assign burst_done_o       = done_q;
  assign burst_words_o      = words_q;
  assign burst_count_o      = count_q;

endmodule

// File: tb/tb_fifo_write_gen.sv
// Directed bench for fifo_write_gen: one unlimited-burst instance and one
// instance with BURST_MAX=5, sharing the FIFO flags and pattern controls.
module tb_fifo_write_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en0, en5;
  logic [1:0] mode;
  logic [7:0] seed;
  logic       ae, af, full;
  bit         sel;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  bit         seen[256];
  int         distinct, zero_seen;

  logic        busy0, done0, busy5, done5;
  logic [15:0] words0, count0, words5, count5;

  always #5 clk = ~clk;

  fifo_write_gen_if #(.DATA_W(8)) if0 ();
  fifo_write_gen_if #(.DATA_W(8)) if5 ();

  assign if0.almost_empty = ae;
  assign if0.almost_full  = af;
  assign if0.full         = full;
  assign if5.almost_empty = ae;
  assign if5.almost_full  = af;
  assign if5.full         = full;

  fifo_write_gen #(
    .DATA_W(8), .SETTLE_CYC(10), .BURST_MAX(0), .CNT_W(16)
  ) dut0 (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .enable_i      (en0),
    .mode_i        (mode),
    .seed_i        (seed),
    .fifo_if       (if0),
    .busy_o        (busy0),
    .burst_done_o  (done0),
    .burst_words_o (words0),
    .burst_count_o (count0)
  );

  fifo_write_gen #(
    .DATA_W(8), .SETTLE_CYC(10), .BURST_MAX(5), .CNT_W(16)
  ) dut5 (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .enable_i      (en5),
    .mode_i        (mode),
    .seed_i        (seed),
    .fifo_if       (if5),
    .busy_o        (busy5),
    .burst_done_o  (done5),
    .burst_words_o (words5),
    .burst_count_o (count5)
  );

  // Monitored instance
  logic        m_wr, m_busy, m_done;
  logic [7:0]  m_data;
  logic [15:0] m_words, m_count;
  assign m_wr    = sel ? if5.fifo_wr_en : if0.fifo_wr_en;
  assign m_data  = sel ? if5.fifo_wdata : if0.fifo_wdata;
  assign m_busy  = sel ? busy5 : busy0;
  assign m_done  = sel ? done5 : done0;
  assign m_words = sel ? words5 : words0;
  assign m_count = sel ? count5 : count0;

  function automatic logic [7:0] lfsr8(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the first write strobe; lat counts negedges, st counts settle cycles
  task automatic wait_wr(output int lat, output int st);
    lat = 0;
    st  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (m_busy && !m_wr) st++;
      if (m_wr) return;
    end
    check("wr_en_timeout", 0, 1);
  endtask

  // Follow a burst from its first presented word until wr_en drops
  task automatic run_burst(input int af_after, input int full_after, output int acc);
    bit         fin;
    logic [7:0] e;
    acc = 0;
    fin = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (af_after >= 0 && acc == af_after) af = 1'b1;
      if (full_after >= 0 && acc == full_after) begin
        full = 1'b1;
        if (exp_q.size() > 0) check("held_word", {24'd0, m_data}, {24'd0, exp_q[0]});
      end
      if (m_wr && !full) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wdata", {24'd0, m_data}, {24'd0, e});
        end
        if (m_data == 8'h00) zero_seen++;
        if (!seen[m_data]) begin
          seen[m_data] = 1'b1;
          distinct++;
        end
        acc++;
      end
      @(negedge clk);
      if (!m_wr) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) check("burst_stop_timeout", 0, 1);
  endtask

  // Called at the first negedge after the stop edge
  task automatic end_checks(input int acc, input int cnt);
    check("burst_done_hi", {31'd0, m_done}, 1);
    check("burst_words", {16'd0, m_words}, acc);
    check("wdata_cleared", {24'd0, m_data}, 0);
    check("busy_after_stop", {31'd0, m_busy}, 0);
    check("burst_count", {16'd0, m_count}, cnt);
    @(negedge clk);
    check("burst_done_lo", {31'd0, m_done}, 0);
  endtask

  initial begin
    int         lat, st, acc, cnt_seen;
    logic [7:0] x;
    rst_n = 1'b0;
    en0 = 1'b0; en5 = 1'b0; mode = 2'd0; seed = 8'h00;
    ae = 1'b0; af = 1'b0; full = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", {31'd0, if0.fifo_wr_en}, 0);
    check("rst_wdata", {24'd0, if0.fifo_wdata}, 0);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_done", {31'd0, done0}, 0);
    check("rst_words", {16'd0, words0}, 0);
    check("rst_count", {16'd0, count0}, 0);
    check("rst_wr_en5", {31'd0, if5.fifo_wr_en}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: increment from 0, almost_full after 20 words, mid-burst mode/seed change ignored
    sel = 1'b0; en0 = 1'b1; mode = 2'd0; seed = 8'h00;
    for (int i = 0; i <= 20; i++) exp_q.push_back(8'(i));
    ae = 1'b1;
    wait_wr(lat, st);
    check("t1_latency", lat, 13);
    check("t1_settle_cycles", st, 10);
    seed = 8'h77; mode = 2'd2;
    run_burst(20, -1, acc);
    check("t1_accepted", acc, 21);
    end_checks(21, 1);
    af = 1'b0; ae = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);

    // 2: burst limit of 5 with wrap-around data
    sel = 1'b1; en0 = 1'b0; en5 = 1'b1; mode = 2'd0; seed = 8'hFE;
    x = 8'hFE;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(x);
      x = x + 8'd1;
    end
    ae = 1'b1;
    wait_wr(lat, st);
    check("t2_latency", lat, 13);
    run_burst(-1, -1, acc);
    check("t2_accepted", acc, 5);
    end_checks(5, 1);
    ae = 1'b0; en5 = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);

    // 3: LFSR from zero seed, 256 words so the 256th repeats the first
    sel = 1'b0; en0 = 1'b1; mode = 2'd1; seed = 8'h00;
    x = 8'h01;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(x);
      x = lfsr8(x);
    end
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct = 0; zero_seen = 0;
    ae = 1'b1;
    wait_wr(lat, st);
    run_burst(255, -1, acc);
    check("t3_accepted", acc, 256);
    check("t3_distinct", distinct, 255);
    check("t3_zero_seen", zero_seen, 0);
    end_checks(256, 2);
    af = 1'b0; ae = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);

    // 4: full for 3 cycles after 7 words; the word presented while full is not counted
    mode = 2'd0; seed = 8'h40;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h40 + 8'(i));
    ae = 1'b1;
    wait_wr(lat, st);
    run_burst(-1, 7, acc);
    check("t4_accepted", acc, 7);
    end_checks(7, 3);
    @(negedge clk);
    full = 1'b0; ae = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);

    // 5: enable dropped in SETTLE, then a fresh edge gets the full settle time
    ae = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_settle_entry", {31'd0, m_busy}, 1);
    repeat (3) @(negedge clk);
    en0 = 1'b0;
    @(negedge clk);
    check("t5_abort_idle", {31'd0, m_busy}, 0);
    cnt_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m_wr) cnt_seen++;
    end
    check("t5_no_write", cnt_seen, 0);
    ae = 1'b0;
    repeat (4) @(negedge clk);
    en0 = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h40 + 8'(i));
    ae = 1'b1;
    wait_wr(lat, st);
    check("t5_latency", lat, 13);
    check("t5_settle_cycles", st, 10);
    run_burst(2, -1, acc);
    check("t5_accepted", acc, 3);
    end_checks(3, 4);
    af = 1'b0; ae = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);

    // 6: async reset mid-WRITE; a level held high across release must not retrigger
    mode = 2'd0; seed = 8'h00;
    ae = 1'b1;
    wait_wr(lat, st);
    check("t6_latency", lat, 13);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_wr_en", {31'd0, if0.fifo_wr_en}, 0);
    check("t6_rst_wdata", {24'd0, if0.fifo_wdata}, 0);
    check("t6_rst_busy", {31'd0, busy0}, 0);
    check("t6_rst_words", {16'd0, words0}, 0);
    check("t6_rst_count", {16'd0, count0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_busy) cnt_seen++;
    end
    check("t6_no_retrigger", cnt_seen, 0);
    ae = 1'b0;
    repeat (5) @(negedge clk);
    ae = 1'b1;
    wait_wr(lat, st);
    check("t6_new_edge_latency", lat, 13);
    en0 = 1'b0;
    @(negedge clk);
    check("t6_disable_done", {31'd0, m_done}, 1);
    check("t6_disable_words", {16'd0, m_words}, 1);
    check("t6_disable_count", {16'd0, m_count}, 1);
    check("t6_disable_wr_en", {31'd0, m_wr}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
